// File: rtl/riscstrong_pkg.sv
// riscstrong_pkg: shared definitions for the RiscStrong address path.
//   XLEN_DEF      default address/data width
//   size_e        access size encodings (byte/half/word/reserved)
//   is_misaligned alignment check of an address against an access size
package riscstrong_pkg;

   localparam int unsigned XLEN_DEF = 32;

   typedef enum logic [1:0] {
      SZ_B   = 2'b00,
      SZ_H   = 2'b01,
      SZ_W   = 2'b10,
      SZ_RSV = 2'b11
   } size_e;

   // Only the two low address bits matter for sizes up to a word.
   function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a_lo);
      logic m;
      m = 1'b0;
      case (size_e'(sz))
         SZ_H:    m = a_lo[0];
         SZ_W:    m = (a_lo != 2'b00);
         SZ_RSV:  m = 1'b1;
         default: m = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/pipe_slice.sv
// pipe_slice: one valid/ready register stage with synchronous flush.
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               clears the stage valid on the next edge
//   in_valid/in_ready   upstream handshake
//   in_data [W-1:0]     upstream payload
//   out_valid/out_ready downstream handshake
//   out_data [W-1:0]    registered payload, held while stalled
module pipe_slice #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   // The stage can take a new item when empty or when its item leaves this cycle.
   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_data <= in_data;
         end
      end
   end

endmodule

// File: rtl/addr_gen_pipe.sv
// addr_gen_pipe: two-stage effective-address generator (base + sign-extended offset).
// Stage 1 adds the low SPLIT bits and registers the carry; stage 2 finishes the
// upper half, applies clear_lsb and (optionally) the alignment check.
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                synchronous pipeline kill; blocks acceptance this cycle
//   in_valid/in_ready    request handshake
//   base [XLEN-1:0]      base address
//   offset [IMM_W-1:0]   signed immediate
//   size [1:0]           access size (riscstrong_pkg::size_e)
//   clear_lsb            force result bit0 to 0
//   out_valid/out_ready  result handshake
//   addr [XLEN-1:0]      effective address, modulo 2^XLEN
//   misalign             alignment error; tied to 0 unless ADDR_GEN_MISALIGN_EN is defined
module addr_gen_pipe
   import riscstrong_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEF,
   parameter int unsigned IMM_W = 12,
   parameter int unsigned SPLIT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  base,
   input  logic [IMM_W-1:0] offset,
   input  logic [1:0]       size,
   input  logic             clear_lsb,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  addr,
   output logic             misalign
);

   localparam int unsigned HW = XLEN - SPLIT;
`ifdef ADDR_GEN_MISALIGN_EN
   localparam int unsigned S1W = 2 + 1 + 1 + SPLIT + 2 * HW;
   localparam int unsigned S2W = XLEN + 1;
`else
   localparam int unsigned S1W = 1 + 1 + SPLIT + 2 * HW;
   localparam int unsigned S2W = XLEN;
`endif

   // ---------------- stage 1: low-half add ----------------
   logic [XLEN-1:0]  off_ext;
   logic [SPLIT-1:0] lo_sum;
   logic             lo_carry;
   logic [S1W-1:0]   s1_in;
   logic [S1W-1:0]   s1_out;
   logic             s1_valid;
   logic             s1_in_ready;

   assign off_ext = {{(XLEN-IMM_W){offset[IMM_W-1]}}, offset};
   assign {lo_carry, lo_sum} = {1'b0, base[SPLIT-1:0]} + {1'b0, off_ext[SPLIT-1:0]};

`ifdef ADDR_GEN_MISALIGN_EN
   assign s1_in = {size, clear_lsb, lo_carry, lo_sum, base[XLEN-1:SPLIT], off_ext[XLEN-1:SPLIT]};
`else
   logic unused_size;
   assign unused_size = ^size;
   assign s1_in = {clear_lsb, lo_carry, lo_sum, base[XLEN-1:SPLIT], off_ext[XLEN-1:SPLIT]};
`endif

   // Flush gating lives here; the slice itself only sees its local readiness.
   assign in_ready = !flush && s1_in_ready;

   logic             s2_in_ready;

   pipe_slice #(.W(S1W)) u_s1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (s1_in_ready),
      .in_data   (s1_in),
      .out_valid (s1_valid),
      .out_ready (s2_in_ready),
      .out_data  (s1_out)
   );

   // ---------------- stage 2: high-half add + finish ----------------
   logic             s1_clear;
   logic             s1_carry;
   logic [SPLIT-1:0] s1_lo;
   logic [HW-1:0]    s1_base_hi;
   logic [HW-1:0]    s1_off_hi;
   logic [HW-1:0]    hi_sum;
   logic [XLEN-1:0]  sum;
   logic [S2W-1:0]   s2_in;
   logic [S2W-1:0]   s2_out;

`ifdef ADDR_GEN_MISALIGN_EN
   logic [1:0]       s1_size;
   assign {s1_size, s1_clear, s1_carry, s1_lo, s1_base_hi, s1_off_hi} = s1_out;
`else
   assign {s1_clear, s1_carry, s1_lo, s1_base_hi, s1_off_hi} = s1_out;
`endif

   assign hi_sum = s1_base_hi + s1_off_hi + HW'(s1_carry);

   always_comb begin
      sum = {hi_sum, s1_lo};
      if (s1_clear) begin
         sum[0] = 1'b0;
      end
   end

`ifdef ADDR_GEN_MISALIGN_EN
   assign s2_in    = {sum, is_misaligned(s1_size, sum[1:0])};
   assign addr     = s2_out[S2W-1:1];
   assign misalign = s2_out[0];
`else
   assign s2_in    = sum;
   assign addr     = s2_out;
   assign misalign = 1'b0;
`endif

   pipe_slice #(.W(S2W)) u_s2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (s1_valid),
      .in_ready  (s2_in_ready),
      .in_data   (s2_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (s2_out)
   );

endmodule
